// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory access sequencer for a multicycle CPU. Latches the
//                address and store data, holds a request until the memory
//                acknowledges or the request times out, and captures read
//                data into MDR and, on fetches, the instruction register.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] Instruction,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic [31:0] MDR,
    output logic        Busy,
    output logic        AccessErr
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_WAIT     = 1'b1;
    localparam logic [7:0] c_TIMEOUT_MAX = 8'hFF;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_irwrite;
    logic        r_is_read;
    logic [31:0] w_sel_addr;
    logic        w_cmd;
    logic        w_misaligned;
    logic        w_start;
    logic        w_bad_addr;
    logic        w_done;
    logic        w_timeout;

    assign w_sel_addr   = IorD ? ALUOut : PC;
    assign w_cmd        = MemRead | MemWrite;
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);

    assign Busy   = (r_state == c_ST_WAIT);
    assign OpCode = Instruction[31:26];
    assign Funct  = Instruction[5:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bad_addr  = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // A misaligned command is rejected without ever raising mem_req
                if (w_cmd) begin
                    if (w_misaligned) begin
                        w_bad_addr = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                // Ack wins over timeout, so an ack at the final count still completes
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_TIMEOUT_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Timeout counter: cleared at start, advances each unacknowledged WAIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (w_start) begin
            r_cnt <= 8'd0;
        end else if ((r_state == c_ST_WAIT) && !w_done && !w_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Request side: latch the access at start, drop the request on ack or timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            r_irwrite <= 1'b0;
            r_is_read <= 1'b0;
        end else if (w_start) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= w_sel_addr;
            mem_wdata <= WriteData;
            r_irwrite <= IRWrite;
            // Write has priority when both commands are raised together
            r_is_read <= ~MemWrite;
        end else if (w_done || w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    // Read data capture into MDR and, for fetches, the instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MDR         <= 32'd0;
            Instruction <= 32'd0;
        end else if (w_done && r_is_read) begin
            MDR <= mem_rdata;
            if (r_irwrite) begin
                Instruction <= mem_rdata;
            end
        end
    end

    // Error pulse lasts exactly one cycle after a rejected or timed-out access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AccessErr <= 1'b0;
        end else begin
            AccessErr <= w_bad_addr | w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. Expected requests
//                are queued as stimulus is applied and popped when the DUT
//                raises mem_req; data-path results are checked per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        IorD;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic [31:0] WriteData;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] MDR;
    logic        Busy;
    logic        AccessErr;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   passes;
    logic r_prev_req;

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .IorD        (IorD),
        .PC          (PC),
        .ALUOut      (ALUOut),
        .WriteData   (WriteData),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .Instruction (Instruction),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .MDR         (MDR),
        .Busy        (Busy),
        .AccessErr   (AccessErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request monitor: every new mem_req must match the oldest queued expectation
    always @(negedge clk) begin
        if (mem_req === 1'b1 && r_prev_req !== 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_req: got addr %h, required no request", mem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we || mem_wdata !== e.wdata)
                    $display("FAIL req_fields: got addr %h we %b wdata %h, required addr %h we %b wdata %h",
                             mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
                else
                    passes = passes + 1;
            end
        end
        r_prev_req = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; queue the request it should produce
    task automatic start_access(input logic rd, input logic wr, input logic irw, input logic iord,
                                input logic [31:0] pc_v, input logic [31:0] alu_v,
                                input logic [31:0] wd);
        logic [31:0] sel;
        sel = iord ? alu_v : pc_v;
        if (sel[1:0] == 2'b00) exp_q.push_back('{addr: sel, we: wr, wdata: wd});
        MemRead   = rd;
        MemWrite  = wr;
        IRWrite   = irw;
        IorD      = iord;
        PC        = pc_v;
        ALUOut    = alu_v;
        WriteData = wd;
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks = checks + 1;
        if ({mem_req, mem_we, Busy, AccessErr} !== 4'b0000)
            $display("FAIL reset_ctrl: got req/we/busy/err %b, required 0000", {mem_req, mem_we, Busy, AccessErr});
        else passes = passes + 1;
        checks = checks + 1;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            $display("FAIL reset_bus: got addr %h wdata %h, required 0", mem_addr, mem_wdata);
        else passes = passes + 1;
        checks = checks + 1;
        if (Instruction !== 32'd0 || MDR !== 32'd0 || OpCode !== 6'd0 || Funct !== 6'd0)
            $display("FAIL reset_regs: got ir %h mdr %h, required 0", Instruction, MDR);
        else passes = passes + 1;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int busy_cycles;
        busy_cycles = 0;
        start_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0);
        busy_cycles += int'(Busy);
        tick();
        busy_cycles += int'(Busy);
        tick();
        busy_cycles += int'(Busy);
        mem_rdata = 32'h8C82_0008;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        busy_cycles += int'(Busy);
        checks = checks + 1;
        if (busy_cycles != 3) $display("FAIL fetch_busy_len: got %0d cycles, required 3", busy_cycles);
        else passes = passes + 1;
        checks = checks + 1;
        if (Instruction !== 32'h8C82_0008 || MDR !== 32'h8C82_0008)
            $display("FAIL fetch_data: got ir %h mdr %h, required 8c820008", Instruction, MDR);
        else passes = passes + 1;
        checks = checks + 1;
        if (OpCode !== 6'h23 || Funct !== 6'h08)
            $display("FAIL fetch_decode: got op %h funct %h, required 23 08", OpCode, Funct);
        else passes = passes + 1;
        checks = checks + 1;
        if (mem_req !== 1'b0) $display("FAIL fetch_req_drop: got %b, required 0", mem_req);
        else passes = passes + 1;
    endtask

    task automatic test_load();
        start_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0100, 32'h0);
        mem_rdata = 32'hDEAD_BEEF;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (MDR !== 32'hDEAD_BEEF) $display("FAIL load_mdr: got %h, required deadbeef", MDR);
        else passes = passes + 1;
        checks = checks + 1;
        if (Instruction !== 32'h8C82_0008) $display("FAIL load_ir_kept: got %h, required 8c820008", Instruction);
        else passes = passes + 1;
        checks = checks + 1;
        if (Busy !== 1'b0) $display("FAIL load_busy: got %b, required 0", Busy);
        else passes = passes + 1;
    endtask

    task automatic test_store();
        start_access(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 32'h1234_5678);
        checks = checks + 1;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || Busy !== 1'b1)
            $display("FAIL store_bus: got we %b wdata %h busy %b, required 1 12345678 1", mem_we, mem_wdata, Busy);
        else passes = passes + 1;
        // Inputs changing in WAIT must not disturb the held request
        MemRead = 1'b1; IorD = 1'b0; PC = 32'h0000_0040; WriteData = 32'h0;
        tick();
        MemRead = 1'b0;
        checks = checks + 1;
        if (mem_addr !== 32'h0000_0200 || mem_wdata !== 32'h1234_5678)
            $display("FAIL store_hold: got addr %h wdata %h, required 00000200 12345678", mem_addr, mem_wdata);
        else passes = passes + 1;
        mem_rdata = 32'hFFFF_FFFF;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (MDR !== 32'hDEAD_BEEF || Instruction !== 32'h8C82_0008 || mem_we !== 1'b0)
            $display("FAIL store_no_load: got mdr %h ir %h we %b, required deadbeef 8c820008 0", MDR, Instruction, mem_we);
        else passes = passes + 1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0;
        logic [31:0] d1;
        d0 = $urandom;
        d1 = $urandom;
        start_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0300, 32'h0);
        mem_rdata = d0;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (MDR !== d0 || Busy !== 1'b0) $display("FAIL b2b_first: got mdr %h busy %b, required %h 0", MDR, Busy, d0);
        else passes = passes + 1;
        start_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0304, 32'h0);
        checks = checks + 1;
        if (Busy !== 1'b1) $display("FAIL b2b_restart: got busy %b, required 1", Busy);
        else passes = passes + 1;
        mem_rdata = d1;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (MDR !== d1 || Instruction !== d1) $display("FAIL b2b_second: got mdr %h ir %h, required %h", MDR, Instruction, d1);
        else passes = passes + 1;
    endtask

    task automatic test_misalign();
        logic [31:0] mdr_before;
        mdr_before = MDR;
        start_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0102, 32'h0);
        checks = checks + 1;
        if (AccessErr !== 1'b1 || mem_req !== 1'b0 || Busy !== 1'b0)
            $display("FAIL misalign_err: got err %b req %b busy %b, required 1 0 0", AccessErr, mem_req, Busy);
        else passes = passes + 1;
        // Ack while idle must be ignored
        mem_rdata = 32'hBAD0_BAD0;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (AccessErr !== 1'b0) $display("FAIL misalign_pulse: got err %b, required 0", AccessErr);
        else passes = passes + 1;
        checks = checks + 1;
        if (MDR !== mdr_before || Busy !== 1'b0) $display("FAIL idle_ack: got mdr %h busy %b, required %h 0", MDR, Busy, mdr_before);
        else passes = passes + 1;
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] mdr_before;
        mdr_before = MDR;
        n = 0;
        start_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0400, 32'h0);
        while (mem_req === 1'b1 && n < 400) begin
            n = n + 1;
            tick();
        end
        checks = checks + 1;
        if (n != 256) $display("FAIL timeout_len: got %0d cycles, required 256", n);
        else passes = passes + 1;
        checks = checks + 1;
        if (AccessErr !== 1'b1 || Busy !== 1'b0) $display("FAIL timeout_err: got err %b busy %b, required 1 0", AccessErr, Busy);
        else passes = passes + 1;
        tick();
        checks = checks + 1;
        if (AccessErr !== 1'b0 || MDR !== mdr_before)
            $display("FAIL timeout_after: got err %b mdr %h, required 0 %h", AccessErr, MDR, mdr_before);
        else passes = passes + 1;
    endtask

    task automatic test_reset_mid();
        start_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0500, 32'h0);
        tick();
        #2 reset = 1'b0;
        #1;
        checks = checks + 1;
        if ({mem_req, mem_we, Busy, AccessErr} !== 4'b0000 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            $display("FAIL midreset_ctrl: got req/we/busy/err %b addr %h, required 0000 0", {mem_req, mem_we, Busy, AccessErr}, mem_addr);
        else passes = passes + 1;
        checks = checks + 1;
        if (MDR !== 32'd0 || Instruction !== 32'd0 || OpCode !== 6'd0 || Funct !== 6'd0)
            $display("FAIL midreset_regs: got mdr %h ir %h, required 0", MDR, Instruction);
        else passes = passes + 1;
        tick();
        reset = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks = checks + 1;
        if (MDR !== 32'd0 || Instruction !== 32'd0 || Busy !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL late_ack: got mdr %h ir %h busy %b req %b, required 0", MDR, Instruction, Busy, mem_req);
        else passes = passes + 1;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        r_prev_req = 1'b0;
        reset      = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        PC         = 32'h0;
        ALUOut     = 32'h0;
        WriteData  = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;

        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_reset_mid();

        tick();
        checks = checks + 1;
        if (exp_q.size() != 0) $display("FAIL missing_req: got %0d requests pending, required 0", exp_q.size());
        else passes = passes + 1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
